// File: rtl/bypass_pipe_pkg.sv
// Shared widths and ALU opcode encodings for the MEM/WB bypass pipe.
// Flag-only opcodes update condition codes and never write the register file.
package bypass_pipe_pkg;
    localparam int REGAW_D = 4;
    localparam int DATAW_D = 32;
    localparam int ALUAW_D = 4;

    localparam logic [ALUAW_D-1:0] OP_LDR = 4'h0;
    localparam logic [ALUAW_D-1:0] OP_ADD = 4'h4;
    localparam logic [ALUAW_D-1:0] OP_TST = 4'h8;
    localparam logic [ALUAW_D-1:0] OP_TEQ = 4'h9;
    localparam logic [ALUAW_D-1:0] OP_CMP = 4'hA;
    localparam logic [ALUAW_D-1:0] OP_CMN = 4'hB;
endpackage

// File: rtl/bypass_pipe_fwd_sel.sv
// Per-operand forwarding mux: MEM-stage writer beats WB-stage writer beats RF.
// A load in MEM has no data yet, so it raises load_hit instead of forwarding.
module fwd_sel
    import bypass_pipe_pkg::*;
#(
    parameter int REGAW = REGAW_D,
    parameter int DATAW = DATAW_D
) (
    input  logic             a_we,
    input  logic             a_is_load,
    input  logic [REGAW-1:0] a_rd,
    input  logic [DATAW-1:0] a_data,
    input  logic             b_we,
    input  logic [REGAW-1:0] b_rd,
    input  logic [DATAW-1:0] b_data,
    input  logic [REGAW-1:0] rs,
    input  logic [DATAW-1:0] rf,
    output logic [DATAW-1:0] op,
    output logic             load_hit
);
    logic w_a_match;
    logic w_b_match;

    assign w_a_match = a_we && (a_rd == rs);
    assign w_b_match = b_we && (b_rd == rs);
    assign load_hit  = w_a_match && a_is_load;

    always_comb begin
        op = rf;
        if (w_a_match && !a_is_load) op = a_data;
        else if (w_b_match)          op = b_data;
    end
endmodule

// File: rtl/bypass_pipe.sv
// Two-stage MEM/WB result pipe with operand forwarding into decode.
// Only forwards and flags load-use hazards; bubble insertion is the caller's job.
module bypass_pipe
    import bypass_pipe_pkg::*;
#(
    parameter int REGAW = REGAW_D,
    parameter int DATAW = DATAW_D,
    parameter int ALUAW = ALUAW_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [ALUAW-1:0] ex_opcode,
    input  logic [REGAW-1:0] ex_rd,
    input  logic [DATAW-1:0] ex_result,
    input  logic             ex_is_load,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             stall,
    input  logic             flush,
    input  logic [REGAW-1:0] id_rs1,
    input  logic [REGAW-1:0] id_rs2,
    input  logic [DATAW-1:0] id_rf1,
    input  logic [DATAW-1:0] id_rf2,
    output logic [DATAW-1:0] op1,
    output logic [DATAW-1:0] op2,
    output logic             load_use_stall,
    output logic             wb_we,
    output logic [REGAW-1:0] wb_rd,
    output logic [DATAW-1:0] wb_data
);
    logic             r_a_valid, r_a_we, r_a_is_load;
    logic [REGAW-1:0] r_a_rd;
    logic [DATAW-1:0] r_a_data;
    logic             r_b_valid, r_b_we;
    logic [REGAW-1:0] r_b_rd;
    logic [DATAW-1:0] r_b_data;

    logic w_a_valid_nxt;
    logic w_flag_op;
    logic w_hit1, w_hit2;

    assign w_a_valid_nxt = ex_valid && !flush;
    assign w_flag_op     = (ex_opcode == ALUAW'(OP_TST)) || (ex_opcode == ALUAW'(OP_TEQ)) ||
                           (ex_opcode == ALUAW'(OP_CMP)) || (ex_opcode == ALUAW'(OP_CMN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid   <= 1'b0;
            r_a_we      <= 1'b0;
            r_a_is_load <= 1'b0;
            r_a_rd      <= '0;
            r_a_data    <= '0;
            r_b_valid   <= 1'b0;
            r_b_we      <= 1'b0;
            r_b_rd      <= '0;
            r_b_data    <= '0;
        end else if (stall) begin
            // A flush during a stall kills the MEM entry but leaves WB frozen
            if (flush) begin
                r_a_valid <= 1'b0;
                r_a_we    <= 1'b0;
            end
        end else begin
            r_a_valid   <= w_a_valid_nxt;
            r_a_we      <= w_a_valid_nxt && !w_flag_op;
            r_a_is_load <= ex_is_load;
            r_a_rd      <= ex_rd;
            r_a_data    <= ex_result;
            r_b_valid   <= r_a_valid;
            r_b_we      <= r_a_we;
            r_b_rd      <= r_a_rd;
            r_b_data    <= r_a_is_load ? mem_rdata : r_a_data;
        end
    end

    fwd_sel #(.REGAW(REGAW), .DATAW(DATAW)) u_fwd1 (
        .a_we(r_a_we), .a_is_load(r_a_is_load), .a_rd(r_a_rd), .a_data(r_a_data),
        .b_we(r_b_we), .b_rd(r_b_rd), .b_data(r_b_data),
        .rs(id_rs1), .rf(id_rf1), .op(op1), .load_hit(w_hit1)
    );

    fwd_sel #(.REGAW(REGAW), .DATAW(DATAW)) u_fwd2 (
        .a_we(r_a_we), .a_is_load(r_a_is_load), .a_rd(r_a_rd), .a_data(r_a_data),
        .b_we(r_b_we), .b_rd(r_b_rd), .b_data(r_b_data),
        .rs(id_rs2), .rf(id_rf2), .op(op2), .load_hit(w_hit2)
    );

    assign load_use_stall = w_hit1 || w_hit2;
    assign wb_we          = r_b_valid && r_b_we;
    assign wb_rd          = r_b_rd;
    assign wb_data        = r_b_data;
endmodule

// File: tb/tb_bypass_pipe.sv
// Directed bench for bypass_pipe: forwarding priority, flag ops, load-use,
// flush, stall and asynchronous reset, with hand-computed expectations.
module tb_bypass_pipe;
    import bypass_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_load, stall, flush;
    logic [3:0]  ex_opcode, ex_rd, id_rs1, id_rs2;
    logic [31:0] ex_result, mem_rdata, id_rf1, id_rf2;
    logic [31:0] op1, op2, wb_data;
    logic        load_use_stall, wb_we;
    logic [3:0]  wb_rd;

    int n_pass = 0;
    int n_total = 0;

    bypass_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_is_load(ex_is_load), .mem_rdata(mem_rdata),
        .stall(stall), .flush(flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rf1(id_rf1), .id_rf2(id_rf2),
        .op1(op1), .op2(op2), .load_use_stall(load_use_stall),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_in(input logic v, input logic [3:0] opc, input logic [3:0] rd,
                         input logic [31:0] res, input logic ld);
        ex_valid = v; ex_opcode = opc; ex_rd = rd; ex_result = res; ex_is_load = ld;
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; mem_rdata = 0;
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rs1 = 0; id_rs2 = 0; id_rf1 = 32'hAAAA; id_rf2 = 32'hBBBB;
        #1;
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_lus", 32'(load_use_stall), 0);
        chk("rst_op1", op1, 32'hAAAA);
        chk("rst_op2", op2, 32'hBBBB);
        tick();
        rst_n = 1'b1;
        tick();

        // ADD r3 = 0x11: forward from A, then from B, then write back
        ex_in(1, OP_ADD, 3, 32'h11, 0);
        tick();
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rs1 = 3; id_rf1 = 32'h1;
        #1;
        chk("add_opA", op1, 32'h11);
        chk("add_wbwe_early", 32'(wb_we), 0);
        tick();
        chk("add_opB", op1, 32'h11);
        chk("add_wb_we", 32'(wb_we), 1);
        chk("add_wb_rd", 32'(wb_rd), 3);
        chk("add_wb_data", wb_data, 32'h11);
        tick();
        chk("add_drained", op1, 32'h1);

        // CMP rd=3 must neither forward nor write
        ex_in(1, OP_CMP, 3, 32'h99, 0);
        tick();
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rf1 = 32'h5;
        #1;
        chk("cmp_opA", op1, 32'h5);
        tick();
        chk("cmp_opB", op1, 32'h5);
        chk("cmp_wb_we", 32'(wb_we), 0);
        tick();

        // LDR r4: load-use hazard, then loaded data forwarded from B
        id_rs1 = 0; id_rf1 = 32'h0;
        ex_in(1, OP_LDR, 4, 32'hDEAD, 1);
        tick();
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rs2 = 4; id_rf2 = 32'h2;
        mem_rdata = 32'hAB;
        #1;
        chk("ldr_lus", 32'(load_use_stall), 1);
        tick();
        mem_rdata = 32'h0;
        #1;
        chk("ldr_op2B", op2, 32'hAB);
        chk("ldr_lus_clear", 32'(load_use_stall), 0);
        chk("ldr_wb_data", wb_data, 32'hAB);
        chk("ldr_wb_rd", 32'(wb_rd), 4);
        tick();
        id_rs2 = 0; id_rf2 = 32'hBBBB;

        // r2=1 then r2=2: the younger writer in A wins over B
        ex_in(1, OP_ADD, 2, 32'h1, 0);
        tick();
        ex_in(1, OP_ADD, 2, 32'h2, 0);
        tick();
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rs1 = 2; id_rs2 = 2; id_rf1 = 32'hF0; id_rf2 = 32'hF1;
        #1;
        chk("b2b_op1", op1, 32'h2);
        chk("b2b_op2", op2, 32'h2);
        tick();
        chk("b2b_op1_B", op1, 32'h2);
        tick();
        id_rs2 = 0; id_rf2 = 32'hBBBB;

        // flush squashes a valid ADD r5
        ex_in(1, OP_ADD, 5, 32'h55, 0);
        flush = 1;
        tick();
        flush = 0;
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rs1 = 5; id_rf1 = 32'h77;
        #1;
        chk("flush_noA", op1, 32'h77);
        tick();
        chk("flush_wb_we", 32'(wb_we), 0);
        chk("flush_noB", op1, 32'h77);

        // stall freezes A (r7) and B (r6) for three cycles
        ex_in(1, OP_ADD, 6, 32'h66, 0);
        tick();
        ex_in(1, OP_ADD, 7, 32'h70, 0);
        tick();
        chk("pre_stall_wb_rd", 32'(wb_rd), 6);
        ex_in(1, OP_ADD, 8, 32'h88, 0);
        stall = 1;
        id_rs1 = 7; id_rf1 = 32'h3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wb_we", 32'(wb_we), 1);
            chk("stall_wb_rd", 32'(wb_rd), 6);
            chk("stall_wb_data", wb_data, 32'h66);
            chk("stall_opA", op1, 32'h70);
        end
        flush = 1;
        tick();
        chk("stflush_opA_gone", op1, 32'h3);
        chk("stflush_wb_rd", 32'(wb_rd), 6);
        chk("stflush_wb_data", wb_data, 32'h66);
        stall = 0; flush = 0;
        ex_in(0, OP_ADD, 0, 0, 0);
        tick();
        chk("stflush_wb_we", 32'(wb_we), 0);
        tick();

        // asynchronous reset with the pipe full
        ex_in(1, OP_ADD, 9, 32'h99, 0);
        tick();
        ex_in(1, OP_ADD, 10, 32'hA0, 0);
        tick();
        ex_in(0, OP_ADD, 0, 0, 0);
        id_rs1 = 10; id_rf1 = 32'h44;
        #1;
        chk("prerst_wb_we", 32'(wb_we), 1);
        chk("prerst_op1", op1, 32'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_we", 32'(wb_we), 0);
        chk("midrst_wb_data", wb_data, 0);
        chk("midrst_op1", op1, 32'h44);
        chk("midrst_lus", 32'(load_use_stall), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_wb_we", 32'(wb_we), 0);
        chk("postrst_op1", op1, 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
